// File: rtl/vga_block_ram_if.sv
// Pixel line buffer bus: one 32-bit word write port and one byte read port.
interface vga_block_ram_if;
   logic        wr_en;
   logic [5:0]  wr_addr;
   logic [31:0] wr_data;
   logic [7:0]  rd_addr;
   logic [7:0]  rd_data;

   modport master (
      output wr_en,
      output wr_addr,
      output wr_data,
      output rd_addr,
      input  rd_data
   );

   modport slave (
      input  wr_en,
      input  wr_addr,
      input  wr_data,
      input  rd_addr,
      output rd_data
   );
endinterface

// File: rtl/vga_block_ram.sv
// 64 x 32-bit line buffer read back as 256 little-endian bytes, with a
// post-reset clear sweep that zeroes one word per cycle.
module vga_block_ram (
   input logic             clk,
   input logic             reset,
   vga_block_ram_if.slave  bus
);

   logic [31:0] mem [64];

   logic        clearing_q, clearing_d;
   logic [5:0]  clr_addr_q, clr_addr_d;
   logic        rd_zero_q, rd_zero_d;
   logic [31:0] rd_word_q;
   logic [1:0]  lane_q, lane_d;

   logic        mem_we;
   logic [5:0]  mem_waddr;
   logic [31:0] mem_wdata;

   // Sweep sequencing: reset parks the sweep at word 0, then it walks 0..63.
   always_comb begin
      clearing_d = clearing_q;
      clr_addr_d = clr_addr_q;
      if (reset) begin
         clearing_d = 1'b1;
         clr_addr_d = 6'd0;
      end else if (clearing_q) begin
         clr_addr_d = clr_addr_q + 6'd1;
         if (clr_addr_q == 6'd63) begin
            clearing_d = 1'b0;
         end
      end
   end

   // Write port steering: the sweep owns the port until it finishes.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = bus.wr_addr;
      mem_wdata = bus.wr_data;
      if (!reset) begin
         if (clearing_q) begin
            mem_we    = 1'b1;
            mem_waddr = clr_addr_q;
            mem_wdata = 32'h0;
         end else begin
            mem_we = bus.wr_en;
         end
      end
   end

   // Read-side control: mask the output while in reset or sweeping.
   always_comb begin
      rd_zero_d = reset | clearing_q;
      lane_d    = bus.rd_addr[1:0];
   end

   // Control state registers.
   always_ff @(posedge clk) begin
      clearing_q <= clearing_d;
      clr_addr_q <= clr_addr_d;
      rd_zero_q  <= rd_zero_d;
      lane_q     <= lane_d;
   end

   // Block RAM: read-first word read alongside the single word write.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
      rd_word_q <= mem[bus.rd_addr[7:2]];
   end

   // Byte lane select on the registered word, little-endian.
   always_comb begin
      bus.rd_data = 8'h00;
      if (!rd_zero_q) begin
         unique case (lane_q)
            2'd0: bus.rd_data = rd_word_q[7:0];
            2'd1: bus.rd_data = rd_word_q[15:8];
            2'd2: bus.rd_data = rd_word_q[23:16];
            2'd3: bus.rd_data = rd_word_q[31:24];
            default: bus.rd_data = 8'h00;
         endcase
      end
   end

endmodule

// File: tb/tb_vga_block_ram.sv
// Self-checking bench: byte-array reference model with a sweep countdown.
module tb_vga_block_ram;

   logic clk = 1'b0;
   logic reset;

   vga_block_ram_if bus ();

   vga_block_ram dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [7:0] mem_m [256];
   int         sweep_left = 64;
   int         n_cmp = 0;
   int         n_bad = 0;

   // One clock: apply inputs, advance the model, compare just after the edge.
   task automatic step(input logic r, input logic we, input logic [5:0] wa,
                       input logic [31:0] wd, input logic [7:0] ra, input string tag);
      logic [7:0] exp;
      reset       = r;
      bus.wr_en   = we;
      bus.wr_addr = wa;
      bus.wr_data = wd;
      bus.rd_addr = ra;
      if (r) begin
         exp        = 8'h00;
         sweep_left = 64;
      end else if (sweep_left > 0) begin
         exp = 8'h00;
         for (int k = 0; k < 4; k++) mem_m[(64 - sweep_left) * 4 + k] = 8'h00;
         sweep_left--;
      end else begin
         exp = mem_m[ra];
         if (we) for (int k = 0; k < 4; k++) mem_m[int'(wa) * 4 + k] = wd[8 * k +: 8];
      end
      @(posedge clk);
      #1;
      n_cmp++;
      assert (bus.rd_data === exp)
      else begin
         n_bad++;
         $error("FAIL %s: rd_data=%02h expected %02h", tag, bus.rd_data, exp);
      end
   endtask

   task automatic read_all(input string tag);
      for (int b = 0; b < 256; b++) step(1'b0, 1'b0, 6'd0, 32'h0, 8'(b), tag);
   endtask

   initial begin
      logic [31:0] w;
      reset       = 1'b1;
      bus.wr_en   = 1'b0;
      bus.wr_addr = '0;
      bus.wr_data = '0;
      bus.rd_addr = '0;
      for (int b = 0; b < 256; b++) mem_m[b] = 8'h00;

      // Reset, then writes attempted during the sweep must be ignored.
      step(1'b1, 1'b1, 6'd3, 32'hDEADBEEF, 8'd12, "reset");
      step(1'b1, 1'b1, 6'd0, 32'hCAFEF00D, 8'd0, "reset_hold");
      for (int i = 0; i < 64; i++)
         step(1'b0, 1'b1, 6'($urandom_range(63)), $urandom, 8'($urandom_range(255)), "sweep0");
      read_all("post_sweep0");

      // Little-endian lane order.
      step(1'b0, 1'b1, 6'd0, 32'h44332211, 8'd0, "le_wr");
      for (int b = 0; b < 4; b++) step(1'b0, 1'b0, 6'd0, 32'h0, 8'(b), "le_rd");

      // Byte value equals byte address across the whole line.
      for (int a = 0; a < 64; a++) begin
         for (int k = 0; k < 4; k++) w[8 * k +: 8] = 8'(a * 4 + k);
         step(1'b0, 1'b1, 6'(a), w, 8'd0, "fill");
      end
      read_all("ramp");
      step(1'b0, 1'b0, 6'd0, 32'h0, 8'd0, "ramp_tail");

      // Read-first on a same-word collision.
      step(1'b0, 1'b1, 6'd5, 32'hAABBCCDD, 8'd0, "rf_setup");
      step(1'b0, 1'b1, 6'd5, 32'h01020304, 8'd20, "rf_old");
      step(1'b0, 1'b0, 6'd0, 32'h0, 8'd20, "rf_new");

      // Independent write and read of different words.
      step(1'b0, 1'b1, 6'd0, 32'h11223344, 8'd0, "ind_setup");
      step(1'b0, 1'b1, 6'd10, 32'h55667788, 8'd0, "ind_rd");
      step(1'b0, 1'b0, 6'd0, 32'h0, 8'd40, "ind_w10");
      step(1'b0, 1'b0, 6'd0, 32'h0, 8'd3, "ind_w0");

      // Random traffic with occasional resets.
      for (int i = 0; i < 400; i++)
         step(($urandom_range(79) == 0), $urandom_range(1), 6'($urandom_range(63)), $urandom,
              8'($urandom_range(255)), "random");
      for (int i = 0; i < 70; i++) step(1'b0, 1'b0, 6'd0, 32'h0, 8'($urandom_range(255)), "drain");

      // Refill nonzero, one-cycle reset, writes ignored during sweep.
      for (int a = 0; a < 64; a++) step(1'b0, 1'b1, 6'(a), $urandom | 32'h01010101, 8'(a), "refill");
      step(1'b1, 1'b0, 6'd0, 32'h0, 8'd7, "pulse");
      for (int i = 0; i < 30; i++)
         step(1'b0, 1'b1, 6'($urandom_range(63)), $urandom, 8'($urandom_range(255)), "sweep1");
      // Mid-sweep reset restarts from word 0.
      step(1'b1, 1'b1, 6'd9, 32'h12345678, 8'd36, "mid_reset");
      for (int i = 0; i < 64; i++)
         step(1'b0, 1'b1, 6'($urandom_range(63)), $urandom, 8'($urandom_range(255)), "sweep2");
      step(1'b0, 1'b1, 6'd2, 32'h9A8B7C6D, 8'd8, "first_wr");
      step(1'b0, 1'b0, 6'd0, 32'h0, 8'd8, "first_wr_rd");
      step(1'b0, 1'b0, 6'd0, 32'h0, 8'd11, "first_wr_rd");
      read_all("final");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/vga_block_ram.md
VGA_BLOCK_RAM -- requirements
Module: vga_block_ram

Interface
REQ-001 Parameters: none; depth fixed at 64 words x 32 bits, presented as 256 bytes (one 256-pixel line, 8-bit color per pixel).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, synchronous to clk, active-high.
REQ-004 wr_en  input  1  write strobe; a word is written on each rising edge where wr_en=1.
REQ-005 wr_addr  input  6  word address, 0..63.
REQ-006 wr_data  input  32  write word (four pixels).
REQ-007 rd_addr  input  8  byte (pixel x) address, 0..255.
REQ-008 rd_data  output  8  registered byte read result.

Function
REQ-009 Storage SHALL be 64 x 32-bit words; byte address B maps to word B[7:2], lane B[1:0].
REQ-010 Lane order SHALL be little-endian: byte {A,2'bkk} = word[A] bits [8k+7:8k]; e.g. wr_data=32'h44332211 at A=0 gives bytes 0..3 = 11,22,33,44.
REQ-011 Writes SHALL replace all four bytes of word[wr_addr] at the rising edge with wr_en=1; no byte masking.
REQ-012 Reads SHALL be synchronous with latency 1: rd_data after edge N equals byte[rd_addr sampled at edge N]; rd_data holds between edges.
REQ-013 A read SHALL occur every cycle regardless of wr_en; there is no read enable.
REQ-014 Read and write to the same word in one cycle SHALL be read-first: rd_data returns the pre-write byte; the new value is visible from the next read.
REQ-015 Reads and writes to different words in one cycle SHALL be fully independent.
REQ-016 Addresses SHALL be used at full width; no out-of-range case exists, no wrap logic needed.
REQ-017 Contents SHALL power up (configuration) as all zeros.
REQ-018 Implementation SHALL infer a single block RAM (one 32-bit write port, one read port with byte select on registered output); no per-byte flip-flop array.

Reset
REQ-019 reset=1 at an edge SHALL force rd_data to 8'h00 at that edge.
REQ-020 reset SHALL start a clear sweep: words 0..63 written to zero, one per cycle, over 64 consecutive cycles starting the edge after reset deasserts (reset held high stalls the sweep at word 0).
REQ-021 During reset and the sweep, wr_en SHALL be ignored and rd_data SHALL read 8'h00.
REQ-022 Normal operation SHALL resume at the first edge after the 64th clear write; reset asserted mid-sweep SHALL restart the sweep from word 0.
REQ-023 No other state exists; reset does not alter port semantics.

Verification
REQ-024 Write 32'h44332211 at wr_addr=0; then rd_addr=0,1,2,3 on consecutive cycles -> rd_data 11,22,33,44, each one cycle after its address.
REQ-025 Fill all 64 words with {A,A+1,A+2,A+3}-style byte patterns (byte value = byte address); sweep rd_addr 0..255 -> rd_data equals the prior cycle's rd_addr, including 255 -> 8'hFF.
REQ-026 Word 5 = 32'hAABBCCDD; same cycle write 32'h01020304 to word 5 with rd_addr=20 -> rd_data=DD; next read of 20 -> 04.
REQ-027 Write to word 10 while reading byte 0 (word 0 = 11223344) -> rd_data=44, word 10 updated, word 0 unchanged.
REQ-028 Fill memory nonzero, pulse reset 1 cycle, attempt writes during the next 64 cycles -> rd_data 00 throughout; after the sweep all 256 bytes read 00; writes after the sweep take effect.
REQ-029 Assert reset mid-sweep at word 30 -> sweep restarts at word 0; full 64 further cycles elapse before writes are accepted.
